// File: rtl/lock_key_if.sv
// Key-provisioning bus between a key source and lock_key_sequencer.
// master = key source / test-access side, slave = sequencer.
interface lock_key_if #(parameter int KEY_W = 8);
   logic             load_req;
   logic             key_valid;
   logic             key_bit;
   logic             key_ready;
   logic [KEY_W-1:0] key_out;
   logic             fsm_rst;
   logic             busy;
   logic             done;
   logic             err;

   modport master (output load_req, key_valid, key_bit,
                   input  key_ready, key_out, fsm_rst, busy, done, err);
   modport slave  (input  load_req, key_valid, key_bit,
                   output key_ready, key_out, fsm_rst, busy, done, err);
endinterface

// File: rtl/lock_key_sequencer.sv
// Serially loads a KEY_W-bit key, applies it atomically to a locked FSM and releases its reset.
// Optional trailing even-parity bit and ERR state when KEY_PARITY_CHK_EN is defined.
module lock_key_sequencer #(
   parameter int KEY_W    = 8,
   parameter int RST_HOLD = 4
) (
   input  logic          clk,
   input  logic          rst,
   lock_key_if.slave     bus
);
   localparam int IW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
   localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SHIFT  = 3'd1,
`ifdef KEY_PARITY_CHK_EN
      S_PARITY = 3'd2,
      S_ERR    = 3'd5,
`endif
      S_HOLD   = 3'd3,
      S_RUN    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    cnt_q, cnt_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [KEY_W-1:0] shadow_q, shadow_d;
   logic [KEY_W-1:0] key_out_q, key_out_d;
   logic             key_ready_q, key_ready_d;
   logic             fsm_rst_q, fsm_rst_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept;

   // key_ready_q mirrors "state is SHIFT/PARITY", so it doubles as the accept qualifier
   assign accept = bus.key_valid & key_ready_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      shadow_d  = shadow_q;
      key_out_d = key_out_q;
      unique case (state_q)
         S_IDLE: if (bus.load_req) begin
            state_d  = S_SHIFT;
            cnt_d    = '0;
            shadow_d = '0;
         end
         S_SHIFT: if (accept) begin
            shadow_d[cnt_q] = bus.key_bit;
            cnt_d           = cnt_q + 1'b1;
            if (cnt_q == IW'(KEY_W - 1)) begin
               cnt_d = '0;
`ifdef KEY_PARITY_CHK_EN
               state_d = S_PARITY;
`else
               state_d   = S_HOLD;
               hold_d    = '0;
               key_out_d = shadow_d;
`endif
            end
         end
`ifdef KEY_PARITY_CHK_EN
         S_PARITY: if (accept) begin
            if (!(^{shadow_q, bus.key_bit})) begin
               state_d   = S_HOLD;
               hold_d    = '0;
               key_out_d = shadow_q;
            end else begin
               state_d   = S_ERR;
               key_out_d = '0;
            end
         end
         S_ERR: if (bus.load_req) begin
            state_d  = S_SHIFT;
            cnt_d    = '0;
            shadow_d = '0;
         end
`endif
         S_HOLD: begin
            if (hold_q == HW'(RST_HOLD - 1)) state_d = S_RUN;
            else                             hold_d  = hold_q + 1'b1;
         end
         S_RUN: if (bus.load_req) begin
            state_d   = S_SHIFT;
            cnt_d     = '0;
            shadow_d  = '0;
            key_out_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they appear registered on the same edge
   always_comb begin
      key_ready_d = (state_d == S_SHIFT);
      busy_d      = (state_d == S_SHIFT) || (state_d == S_HOLD);
`ifdef KEY_PARITY_CHK_EN
      key_ready_d = key_ready_d || (state_d == S_PARITY);
      busy_d      = busy_d      || (state_d == S_PARITY);
`endif
      fsm_rst_d = (state_d != S_RUN);
      done_d    = (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         hold_q      <= '0;
         shadow_q    <= '0;
         key_out_q   <= '0;
         key_ready_q <= 1'b0;
         fsm_rst_q   <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         shadow_q    <= shadow_d;
         key_out_q   <= key_out_d;
         key_ready_q <= key_ready_d;
         fsm_rst_q   <= fsm_rst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

`ifdef KEY_PARITY_CHK_EN
   logic err_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= (state_d == S_ERR);
   end
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.key_ready = key_ready_q;
   assign bus.key_out   = key_out_q;
   assign bus.fsm_rst   = fsm_rst_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_lock_key_sequencer.sv
// Directed bench for lock_key_sequencer: flag/queue-level model checked every negedge plus literal pins.
module tb_lock_key_sequencer;
   localparam int KEY_W    = 8;
   localparam int RST_HOLD = 4;
`ifdef KEY_PARITY_CHK_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int NBITS = KEY_W + int'(PAR);

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   lock_key_if #(.KEY_W(KEY_W)) bus ();

   lock_key_sequencer #(.KEY_W(KEY_W), .RST_HOLD(RST_HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   // Model: "loading" flag, bits gathered so far, hold countdown, run/err flags.
   bit               m_load = 1'b0, m_run = 1'b0, m_err = 1'b0;
   int               m_nb = 0, m_hold = 0;
   logic [KEY_W-1:0] m_shadow = '0, m_key = '0;

   always @(posedge clk or negedge rst) begin : model
      bit               ld, run, er;
      int               nb, hold;
      logic [KEY_W-1:0] sh, key;
      ld = m_load; run = m_run; er = m_err; nb = m_nb; hold = m_hold; sh = m_shadow; key = m_key;
      if (!rst) begin
         ld = 0; run = 0; er = 0; nb = 0; hold = 0; sh = '0; key = '0;
      end else if (bus.load_req && !ld && hold == 0) begin
         ld = 1; run = 0; er = 0; nb = 0; sh = '0; key = '0;
      end else if (ld) begin
         if (bus.key_valid) begin
            if (nb < KEY_W) begin
               sh[nb] = bus.key_bit;
               nb++;
               if (nb == KEY_W && !PAR) begin ld = 0; key = sh; hold = RST_HOLD; end
            end else begin
               ld = 0;
               if ((($countones(sh) + int'(bus.key_bit)) % 2) == 0) begin key = sh; hold = RST_HOLD; end
               else er = 1;
            end
         end
      end else if (hold > 0) begin
         hold--;
         if (hold == 0) run = 1;
      end
      m_load <= ld; m_run <= run; m_err <= er; m_nb <= nb; m_hold <= hold;
      m_shadow <= sh; m_key <= key;
   end

   always @(negedge clk) begin
      chk("key_ready", bus.key_ready, m_load);
      chk("busy",      bus.busy,      m_load | (m_hold > 0));
      chk("fsm_rst",   bus.fsm_rst,   !m_run);
      chk("done",      bus.done,      m_run);
      chk("err",       bus.err,       m_err);
      chk("key_out",   bus.key_out,   m_key);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start();
      bus.load_req = 1'b1;
      tick();
      bus.load_req = 1'b0;
   endtask

   // Sends KEY_W bits LSB first (plus parity bit when built in), 'gap' idle cycles between bits.
   task automatic send(input logic [KEY_W-1:0] k, input logic pb, input int gap);
      for (int i = 0; i < NBITS; i++) begin
         bus.key_valid = 1'b1;
         bus.key_bit   = (i < KEY_W) ? k[i] : pb;
         tick();
         bus.key_valid = 1'b0;
         if (i < NBITS - 1)
            repeat (gap) begin
               tick();
               chk("stall_key_out", bus.key_out, 0);
               chk("stall_fsm_rst", bus.fsm_rst, 1);
            end
      end
   endtask

   initial begin
      bus.load_req = 1'b0; bus.key_valid = 1'b0; bus.key_bit = 1'b0;
      rst = 1'b0;
      repeat (2) tick();
      chk("rst_fsm_rst", bus.fsm_rst, 1);   chk("rst_key_out", bus.key_out, 0);
      chk("rst_key_ready", bus.key_ready, 0); chk("rst_done", bus.done, 0);
      chk("rst_busy", bus.busy, 0);         chk("rst_err", bus.err, 0);
      rst = 1'b1;
      repeat (3) tick();
      chk("idle_fsm_rst", bus.fsm_rst, 1);  chk("idle_key_ready", bus.key_ready, 0);

      // Full-rate 8'h4D; key_valid held high through HOLD must be ignored
      start();
      chk("shift_key_ready", bus.key_ready, 1);
      send(8'h4D, 1'b0, 0);
      chk("load_key_out", bus.key_out, 8'h4D);
      chk("load_fsm_rst", bus.fsm_rst, 1);
      bus.key_valid = 1'b1;
      repeat (RST_HOLD - 1) tick();
      chk("hold_fsm_rst", bus.fsm_rst, 1);
      bus.key_valid = 1'b0;
      tick();
      chk("run_fsm_rst", bus.fsm_rst, 0); chk("run_done", bus.done, 1);
      chk("run_key_out", bus.key_out, 8'h4D);

      // Re-key to 8'hA5 at full rate
      start();
      chk("rekey_fsm_rst", bus.fsm_rst, 1); chk("rekey_key_out", bus.key_out, 0);
      chk("rekey_done", bus.done, 0);
      send(8'hA5, 1'b0, 0);
      repeat (RST_HOLD) tick();
      chk("a5_done", bus.done, 1); chk("a5_key_out", bus.key_out, 8'hA5);

      // Re-key with a stalled source; second load_req lands in SHIFT and is ignored
      bus.load_req = 1'b1;
      repeat (2) tick();
      bus.load_req = 1'b0;
      chk("ignored_req_ready", bus.key_ready, 1);
      send(8'h3C, 1'b0, 2);
      repeat (RST_HOLD) tick();
      chk("3c_done", bus.done, 1); chk("3c_key_out", bus.key_out, 8'h3C);

`ifdef KEY_PARITY_CHK_EN
      start();
      send(8'h4D, 1'b1, 0);
      chk("perr_err", bus.err, 1); chk("perr_fsm_rst", bus.fsm_rst, 1);
      chk("perr_key_out", bus.key_out, 0);
      repeat (3) tick();
      chk("perr_sticky", bus.err, 1);
      start();
      chk("perr_clear", bus.err, 0);
      send(8'h4D, 1'b0, 0);
      repeat (RST_HOLD) tick();
      chk("par_done", bus.done, 1); chk("par_key_out", bus.key_out, 8'h4D);
`endif

      // Async reset after 3 accepted bits
      start();
      bus.key_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin bus.key_bit = 1'b1; tick(); end
      bus.key_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_key_out", bus.key_out, 0); chk("mid_rst_fsm_rst", bus.fsm_rst, 1);
      chk("mid_rst_busy", bus.busy, 0);
      tick();
      rst = 1'b1;
      tick();

      // Async reset while HOLD shows a key, then a clean load from count 0
      start();
      send(8'h96, 1'b0, 0);
      chk("hold_96", bus.key_out, 8'h96);
      #2 rst = 1'b0;
      #1;
      chk("hold_rst_key_out", bus.key_out, 0); chk("hold_rst_fsm_rst", bus.fsm_rst, 1);
      tick();
      rst = 1'b1;
      tick();
      start();
      send(8'h96, 1'b0, 0);
      repeat (RST_HOLD) tick();
      chk("96_done", bus.done, 1); chk("96_key_out", bus.key_out, 8'h96);

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lock_key_sequencer.md
# lock_key_sequencer

Controller that provisions the secret key of a locked FSM benchmark and sequences its reset. It serially accepts a KEY_W-bit key from a key source over a valid/ready handshake and holds the target FSM in reset while the key is incomplete. It presents the full key atomically on the target's key inputs, then releases the target's reset after a programmable hold. It sits between the key store / test-access path and the locked FSM's `keyinput*` and `rst` pins.

## Interface
Parameters:
- KEY_W, 8: key width in bits (≥1); drives target `keyinput0..keyinput(KEY_W-1)`.
- RST_HOLD, 4: cycles `fsm_rst` stays high after the key is applied (≥1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_req  input  1  start or re-start key load; single-cycle pulse or level, sampled per state.
- key_valid  input  1  key source has a bit on `key_bit`.
- key_bit  input  1  serial key bit, LSB first.
- key_ready  output  1  sequencer accepts a bit this cycle.
- key_out  output  KEY_W  key applied to the target FSM.
- fsm_rst  output  1  active-high reset to the target FSM.
- busy  output  1  load in progress (SHIFT, PARITY, HOLD).
- done  output  1  target running with a valid key.
- err  output  1  parity failure (only with parity check compiled in).

## Operation
- All outputs are registered. Reset values: key_ready=0, key_out=0, fsm_rst=1, busy=0, done=0, err=0. State is IDLE; shift counter and hold counter are 0.
- States and transitions:
  - IDLE: fsm_rst=1. `load_req` goes to SHIFT.
  - SHIFT: key_ready=1, busy=1. Each cycle with key_valid&key_ready shifts `key_bit` into shadow bit [count] and increments count. On the KEY_W-th accepted bit: goes to PARITY if compiled in, else to HOLD.
  - PARITY: key_ready=1. One accepted bit is the parity bit. If even parity over shadow plus parity bit holds, go to HOLD. Otherwise go to ERR.
  - HOLD: key_out loads the shadow on entry; fsm_rst=1, key_ready=0. Goes to RUN after RST_HOLD cycles.
  - RUN: fsm_rst=0, done=1, busy=0.
  - ERR: fsm_rst=1, err=1, key_out=0. `load_req` clears err and goes to SHIFT.
- `load_req` in RUN starts a re-key: next edge fsm_rst=1, done=0, key_out=0, state SHIFT, count=0.
- `load_req` in SHIFT, PARITY or HOLD is ignored. It does not restart the load.
- `key_valid` outside SHIFT/PARITY is ignored. No bit is consumed.
- key_out never shows a partial key. It changes only on HOLD entry (to the new key) or to 0 (reset, re-key, ERR).
- A stalled source (key_valid=0) leaves the sequencer in SHIFT indefinitely with fsm_rst=1. There is no timeout.
- Async reset mid-load discards the shadow and count, and immediately forces fsm_rst=1 and key_out=0.

## Timing
- `load_req` sampled at edge T in IDLE: key_ready=1 from T (after edge).
- Bits are accepted at every edge where key_valid=1, with no bubbles. At full rate, the last key bit is accepted at edge T+KEY_W.
- Without parity: HOLD is entered and key_out is valid after edge T+KEY_W. fsm_rst falls and done rises after edge T+KEY_W+RST_HOLD.
- With parity: every milestone is one edge later.
- fsm_rst changes only on the rising edge. The target samples on the falling clock edge, so it sees reset release half a cycle later.
- Re-key from RUN: fsm_rst=1 one edge after `load_req` is sampled.

## Configuration
- Macro `KEY_PARITY_CHK_EN`.
  - Defined: the PARITY state, the `err` logic and the ERR state are built in; the load takes one extra bit and one extra cycle.
  - Undefined: SHIFT goes straight to HOLD, `err` is tied 0, and the ERR state is not built.

## Test plan
- Reset: with rst=0, all outputs at their reset values. Deassert rst: IDLE, fsm_rst=1, no change without `load_req`.
- Full-rate load, KEY_W=8, RST_HOLD=4, no parity: key bits 1,0,1,1,0,0,1,0 → key_out=8'h4D after edge T+8; fsm_rst=0 and done=1 after edge T+12.
- Stalled source: key_valid toggles 1,0,0,1,… → only valid cycles shift; key_out is unchanged (0) until the 8th accepted bit; fsm_rst stays 1.
- Parity (macro defined): key 8'h4D with parity bit 0 → RUN after edge T+13. Parity bit 1 → err=1, fsm_rst=1, key_out=0. A following `load_req` clears err.
- Re-key: `load_req` in RUN → fsm_rst=1 and key_out=0 next edge. A new key 8'hA5 → RUN with key_out=8'hA5.
- Reset mid-load: assert rst after 3 accepted bits → key_out=0 and fsm_rst=1 immediately. The next load starts at count 0.
